// File: rtl/qspi_cmd_engine.sv
// QSPI command engine: issues an opcode, optional 24-bit address, dummy
// clocks and a multi-byte read in SPI mode 0 on 1, 2 or 4 lanes.
module qspi_cmd_engine #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8,
    parameter int CE_HIGH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic [23:0]      addr,
    input  logic             addr_en,
    input  logic [3:0]       dummy_cycles,
    input  logic [LEN_W-1:0] rd_len,
    input  logic [1:0]       lane_mode,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             sclk,
    output logic             ce_n,
    output logic [3:0]       dq_o,
    output logic [3:0]       dq_oe,
    input  logic [3:0]       dq_i
);
    localparam int HALF = (CLK_DIV < 2) ? 1 : CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GW   = (CE_HIGH > 1) ? $clog2(CE_HIGH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((CE_HIGH > 0) ? CE_HIGH - 1 : 0);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END, GAP} state_t;

    state_t           state, nxt, after_cmd, after_addr, after_dummy;
    logic [23:0]      addr_q, sh, sh_nx;
    logic             a_en;
    logic [3:0]       dummy_q;
    logic [LEN_W-1:0] len_q, bytes_left;
    logic [1:0]       lm;
    logic [4:0]       cnt;           // sclk cycles left in phase (or in byte during DATA)
    logic [DW-1:0]    div;
    logic [GW-1:0]    gap;
    logic [7:0]       rx, rx_nx;
    logic             dual, quad, tick, rise, fall, last_cyc;
    logic [3:0]       out_nx, addr_out, addr_oe;
    logic [4:0]       addr_cyc, byte_cyc;

    assign dual     = (lm == 2'd1);
    assign quad     = (lm == 2'd2);
    assign tick     = (div == DIV_LAST);
    assign rise     = tick && !sclk;
    assign fall     = tick && sclk;
    assign last_cyc = (cnt == 5'd1);

    assign addr_out = quad ? addr_q[23:20] : dual ? {2'b00, addr_q[23:22]} : {3'b000, addr_q[23]};
    assign addr_oe  = quad ? 4'b1111 : dual ? 4'b0011 : 4'b0001;
    assign addr_cyc = quad ? 5'd6 : dual ? 5'd12 : 5'd24;
    assign byte_cyc = quad ? 5'd2 : dual ? 5'd4 : 5'd8;
    assign rx_nx    = quad ? {rx[3:0], dq_i} : dual ? {rx[5:0], dq_i[1:0]} : {rx[6:0], dq_i[1]};

    assign after_dummy = (len_q != '0) ? DATA : END;
    assign after_addr  = (dummy_q != 4'd0) ? DUMMY : after_dummy;
    assign after_cmd   = a_en ? ADDR : after_addr;

    // Next phase once the current one has shifted its last sclk cycle
    always_comb begin
        nxt = END;
        case (state)
            CMD:     nxt = after_cmd;
            ADDR:    nxt = after_addr;
            DUMMY:   nxt = after_dummy;
            default: nxt = END;
        endcase
    end

    // Shift register advance and the lane bits it presents next (opcode is always single lane)
    always_comb begin
        sh_nx  = sh << 1;
        out_nx = {3'b000, sh_nx[23]};
        if (state == ADDR && quad) begin
            sh_nx  = sh << 4;
            out_nx = sh_nx[23:20];
        end else if (state == ADDR && dual) begin
            sh_nx  = sh << 2;
            out_nx = {2'b00, sh_nx[23:22]};
        end
    end

    // Transaction FSM with registered pin and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            a_en       <= 1'b0;
            dummy_q    <= '0;
            len_q      <= '0;
            lm         <= '0;
            sh         <= '0;
            cnt        <= '0;
            bytes_left <= '0;
            div        <= '0;
            gap        <= '0;
            rx         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            sclk       <= 1'b0;
            ce_n       <= 1'b1;
            dq_o       <= '0;
            dq_oe      <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr_q  <= addr;
                    a_en    <= addr_en;
                    dummy_q <= dummy_cycles;
                    len_q   <= rd_len;
                    lm      <= lane_mode;
                    sh      <= {cmd, 16'h0000};
                    cnt     <= 5'd8;
                    dq_o    <= {3'b000, cmd[7]};
                    dq_oe   <= 4'b0001;
                    ce_n    <= 1'b0;
                    busy    <= 1'b1;
                    sclk    <= 1'b0;
                    div     <= '0;
                    state   <= CMD;
                end
                CMD, ADDR, DUMMY, DATA: begin
                    div <= tick ? '0 : div + DW'(1);
                    if (tick)
                        sclk <= ~sclk;
                    // Flash drives on falling sclk, so sample on the cycle sclk rises
                    if (rise && state == DATA) begin
                        rx <= rx_nx;
                        if (last_cyc) begin
                            rd_data  <= rx_nx;
                            rd_valid <= 1'b1;
                        end
                    end
                    if (fall) begin
                        if (!last_cyc) begin
                            cnt <= cnt - 5'd1;
                            if (state == CMD || state == ADDR) begin
                                sh   <= sh_nx;
                                dq_o <= out_nx;
                            end
                        end else if (state == DATA && bytes_left != LEN_W'(1)) begin
                            cnt        <= byte_cyc;
                            bytes_left <= bytes_left - LEN_W'(1);
                        end else begin
                            state <= (state == DATA) ? END : nxt;
                            if (state != DATA) begin
                                case (nxt)
                                    ADDR: begin
                                        sh    <= addr_q;
                                        cnt   <= addr_cyc;
                                        dq_o  <= addr_out;
                                        dq_oe <= addr_oe;
                                    end
                                    DUMMY: begin
                                        cnt   <= {1'b0, dummy_q};
                                        dq_o  <= '0;
                                        dq_oe <= '0;
                                    end
                                    DATA: begin
                                        cnt        <= byte_cyc;
                                        bytes_left <= len_q;
                                        dq_o       <= '0;
                                        dq_oe      <= '0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                END: begin
                    // Hold sclk low for a half period before releasing the flash
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        ce_n  <= 1'b1;
                        dq_oe <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        gap   <= GAP_LAST;
                        state <= GAP;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                GAP: begin
                    if (gap == '0)
                        state <= IDLE;
                    else
                        gap <= gap - GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_cmd_engine.sv
// Scoreboard bench for qspi_cmd_engine with a behavioural flash model.
module tb_qspi_cmd_engine;
    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 8;
    localparam int CE_HIGH = 4;
    localparam int HALF    = CLK_DIV / 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       cmd = '0;
    logic [23:0]      addr = '0;
    logic             addr_en = 1'b0;
    logic [3:0]       dummy_cycles = '0;
    logic [LEN_W-1:0] rd_len = '0;
    logic [1:0]       lane_mode = '0;
    logic             busy, done, rd_valid, sclk, ce_n;
    logic [7:0]       rd_data;
    logic [3:0]       dq_o, dq_oe;
    logic [3:0]       dq_i = '0;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_tx[$];   // {dq_o masked by oe, dq_oe} at each sclk rise
    logic [7:0] exp_rd[$];
    int         exp_done[$]; // sclk rising edges expected in the transaction

    always #5 clk = ~clk;

    qspi_cmd_engine #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CE_HIGH(CE_HIGH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr),
        .addr_en(addr_en), .dummy_cycles(dummy_cycles), .rd_len(rd_len),
        .lane_mode(lane_mode), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .sclk(sclk), .ce_n(ce_n), .dq_o(dq_o),
        .dq_oe(dq_oe), .dq_i(dq_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash model: presents the next read bits after each sclk fall once the data phase is reached
    logic [31:0] fl_data = '0;
    int          fl_start = 1000;
    int          fl_lanes = 1;
    int          fl_falls = 0;
    logic        fl_sp = 1'b0;
    logic [31:0] fl_tmp;
    always @(negedge clk) begin
        if (ce_n) begin
            fl_falls = 0;
            fl_sp = 1'b0;
        end else begin
            if (!sclk && fl_sp) begin
                fl_falls++;
                if (fl_falls >= fl_start) begin
                    fl_tmp = fl_data << ((fl_falls - fl_start) * fl_lanes);
                    case (fl_lanes)
                        4:       dq_i = fl_tmp[31:28];
                        2:       dq_i = {2'b00, fl_tmp[31:30]};
                        default: dq_i = {2'b00, fl_tmp[31], 1'b0};
                    endcase
                end
            end
            fl_sp = sclk;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a bus bit, a read byte or done
    int         edges = 0, lo = 0, hi_s = 0, ce_hi = 1000;
    logic       sclk_p = 1'b0, ce_p = 1'b1;
    logic [7:0] e8;
    int         ed;
    always @(negedge clk) begin
        if (!rst_n) begin
            sclk_p = 1'b0; ce_p = 1'b1; edges = 0; lo = 0; hi_s = 0; ce_hi = 1000;
        end else begin
            if (!ce_n && ce_p) chk("ce_gap_min", 32'(ce_hi >= CE_HIGH), 1);
            if (ce_n && !ce_p) ce_hi = 0;
            if (ce_n) ce_hi++;
            if (sclk && !sclk_p) begin
                edges++;
                chk("sclk_low_len", lo, HALF);
                lo = 0;
                if (dq_oe != 4'b0000) begin
                    chk("tx_expected", 32'(exp_tx.size() > 0), 1);
                    if (exp_tx.size() > 0) begin
                        e8 = exp_tx.pop_front();
                        chk("dq_bits", {dq_o & dq_oe, dq_oe}, e8);
                    end
                end
            end
            if (!sclk && sclk_p) begin
                chk("sclk_high_len", hi_s, HALF);
                hi_s = 0;
            end
            if (sclk) hi_s++;
            else if (!ce_n) lo++;
            else lo = 0;
            if (rd_valid) begin
                chk("rd_expected", 32'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) begin
                    e8 = exp_rd.pop_front();
                    chk("rd_data", rd_data, e8);
                end
            end
            if (done) begin
                chk("done_expected", 32'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) begin
                    ed = exp_done.pop_front();
                    chk("sclk_edges", edges, ed);
                    chk("tx_drained", exp_tx.size(), 0);
                    chk("rd_drained", exp_rd.size(), 0);
                    chk("done_ce_n", ce_n, 1);
                    chk("done_busy", busy, 0);
                end
                edges = 0;
            end
            sclk_p = sclk;
            ce_p = ce_n;
        end
    end

    task automatic setup(input logic [7:0] c, input logic [23:0] a, input logic ae,
                         input logic [3:0] dm, input int len, input logic [1:0] lm,
                         input logic [31:0] data);
        int w;
        logic [23:0] t;
        w = (lm == 2'd2) ? 4 : (lm == 2'd1) ? 2 : 1;
        for (int i = 7; i >= 0; i--) exp_tx.push_back({3'b000, c[i], 4'b0001});
        if (ae) begin
            for (int k = 0; k < 24 / w; k++) begin
                t = a << (k * w);
                case (w)
                    4:       exp_tx.push_back({t[23:20], 4'b1111});
                    2:       exp_tx.push_back({2'b00, t[23:22], 4'b0011});
                    default: exp_tx.push_back({3'b000, t[23], 4'b0001});
                endcase
            end
        end
        for (int i = 0; i < len; i++) exp_rd.push_back(data[31 - 8 * i -: 8]);
        exp_done.push_back(8 + (ae ? 24 / w : 0) + int'(dm) + len * (8 / w));
        fl_data = data;
        fl_lanes = w;
        fl_start = 8 + (ae ? 24 / w : 0) + int'(dm);
        cmd = c; addr = a; addr_en = ae; dummy_cycles = dm;
        rd_len = LEN_W'(len); lane_mode = lm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 2000 && exp_done.size() != 0; n++) @(negedge clk);
        chk("done_timeout", exp_done.size(), 0);
        if (exp_done.size() != 0) begin
            exp_tx.delete(); exp_rd.delete(); exp_done.delete();
        end
    endtask

    task automatic gap_wait();
        repeat (CE_HIGH + 3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ce_n", ce_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_dq", {dq_oe, dq_o}, 0);
        chk("rst_flags", {busy, done, rd_valid}, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Read ID straight after reset
        setup(8'h9F, 24'h000000, 1'b0, 4'd0, 3, 2'd0, 32'hEF401800);
        pulse_start(); wait_done(); gap_wait();

        // Quad read with dummy cycles
        setup(8'hEB, 24'h123456, 1'b1, 4'd4, 2, 2'd2, 32'hA53C0000);
        pulse_start(); wait_done(); gap_wait();

        // Write enable, then a start inside the gap that must be dropped
        setup(8'h06, 24'h000000, 1'b0, 4'd0, 0, 2'd0, 32'h0);
        pulse_start(); wait_done();
        cmd = 8'h9F;
        pulse_start();
        repeat (2) @(negedge clk);
        chk("gap_start_ce_n", ce_n, 1);
        chk("gap_start_busy", busy, 0);
        gap_wait();
        chk("gap_start_idle", {busy, ce_n}, 2'b01);

        // Second start mid-CMD must not disturb the opcode
        setup(8'h06, 24'h000000, 1'b0, 4'd0, 0, 2'd0, 32'h0);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("busy_mid_cmd", busy, 1);
        cmd = 8'h05;
        pulse_start(); wait_done(); gap_wait();

        // Dual read and single read with lane_mode 3
        setup(8'h3B, 24'hABCDEF, 1'b1, 4'd8, 1, 2'd1, 32'h96000000);
        pulse_start(); wait_done(); gap_wait();
        setup(8'h03, 24'h000102, 1'b1, 4'd0, 2, 2'd3, 32'h5AC30000);
        pulse_start(); wait_done(); gap_wait();

        // Reset during ADDR aborts without done; next start runs at once
        setup(8'hEB, 24'h123456, 1'b1, 4'd4, 2, 2'd2, 32'hA53C0000);
        pulse_start();
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ce_n", ce_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_flags", {busy, done, rd_valid}, 0);
        exp_tx.delete(); exp_rd.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        setup(8'h9F, 24'h000000, 1'b0, 4'd0, 3, 2'd0, 32'hEF401800);
        pulse_start(); wait_done(); gap_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
